// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port shared by the loader and its host.
// Stream handshake: a byte moves on a rising edge where in_valid && in_ready; the source holds in_data while in_valid is high and in_ready is low.
interface program_loader_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/program_loader.sv
// Packs a little-endian byte stream, three bytes per word, into instruction words.
// Each word is written to consecutive memory addresses, starting at a latched base address.
module program_loader #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  program_loader_if.slave   bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        fsm_state
);
  localparam int HI_W = INSTR_W - 16;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         byte_idx;
  logic [7:0]         byte0, byte1;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W:0]    remain_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [INSTR_W-1:0] wr_data_q;
  logic               err_q;
  logic               ready_c, wr_en_c, busy_c, done_c;
  logic               xfer;
  logic               start_ok;

  assign xfer     = ready_c && bus.in_valid;
  assign start_ok = (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    wr_en_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (word_count == '0) ? DONE : LOAD;
      end
      LOAD: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
        if (bus.in_valid && byte_idx == 2'd2) state_d = WRITE;
      end
      WRITE: begin
        wr_en_c = 1'b1;
        busy_c  = 1'b1;
        state_d = (remain_q == (ADDR_W+1)'(1)) ? DONE : LOAD;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The outgoing word and address are captured with the third byte so they
  // hold steady after the write strobe until the next word replaces them.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx  <= 2'd0;
      byte0     <= 8'd0;
      byte1     <= 8'd0;
      addr_q    <= '0;
      remain_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q   <= base_addr;
        remain_q <= word_count;
        err_q    <= 1'b0;
        byte_idx <= 2'd0;
      end
      if (xfer) begin
        case (byte_idx)
          2'd0: begin
            byte0    <= bus.in_data;
            byte_idx <= 2'd1;
          end
          2'd1: begin
            byte1    <= bus.in_data;
            byte_idx <= 2'd2;
          end
          default: begin
            wr_data_q <= {bus.in_data[HI_W-1:0], byte1, byte0};
            wr_addr_q <= addr_q;
            byte_idx  <= 2'd0;
            if ((bus.in_data >> HI_W) != 8'd0) err_q <= 1'b1;
          end
        endcase
      end
      if (state_q == WRITE) begin
        addr_q   <= addr_q + ADDR_W'(1);
        remain_q <= remain_q - (ADDR_W+1)'(1);
      end
    end
  end

  assign bus.in_ready = ready_c;
  assign bus.wr_en    = wr_en_c;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_c;
  assign done         = done_c;
  assign err          = err_q;
  assign fsm_state    = state_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: scoreboarded writes plus timing, reset and error checks.
module tb_program_loader;
  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   word_count = '0;
  logic              busy, done, err;
  logic [1:0]        fsm_state;

  program_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+INSTR_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (exp_q.size() == 0) check("unexpected_wr", {bus.wr_addr, bus.wr_data}, 32'hDEAD);
      else check("wr_addr_data", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
    end
  end

  task automatic cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    cycle();
    start      = 1'b0;
  endtask

  // Sends one byte; optional idle gap before it, optionally poking start during the gap.
  task automatic send_byte(input logic [7:0] d, input int gap_max, input bit poke);
    int gap;
    bit ok;
    gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    for (int i = 0; i < gap; i++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom_range(0, 255));
      if (poke) begin
        start      = 1'($urandom_range(0, 1));
        base_addr  = 12'd100;
        word_count = 13'd7;
      end
      cycle();
      start = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      cycle();
    end
    bus.in_valid = 1'b0;
    if (!ok) check("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [7:0] b0, b1, b2, input int gap_max, input bit poke);
    send_byte(b0, gap_max, poke);
    send_byte(b1, gap_max, poke);
    send_byte(b2, gap_max, poke);
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_wr_data", {13'd0, bus.wr_data}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);

    // Basic two-word load at base 2.
    push_exp(12'd2, 19'h18A2F);
    push_exp(12'd3, 19'h20305);
    do_start(12'd2, 13'd2);
    check("t2_busy", {31'd0, busy}, 32'd1);
    send_word(8'h2F, 8'h8A, 8'h01, 0, 1'b0);
    check("t2_wr_lat", {31'd0, bus.wr_en}, 32'd1);
    check("t2_ready_wr", {31'd0, bus.in_ready}, 32'd0);
    cycle();
    check("t2_ready_after", {31'd0, bus.in_ready}, 32'd1);
    send_word(8'h05, 8'h03, 8'h02, 0, 1'b0);
    check("t2_wr_lat2", {31'd0, bus.wr_en}, 32'd1);
    cycle();
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_done_busy", {31'd0, busy}, 32'd0);
    check("t2_err", {31'd0, err}, 32'd0);
    cycle();
    check("t2_done_pulse", {31'd0, done}, 32'd0);
    check("t2_hold_addr", {20'd0, bus.wr_addr}, 32'd3);
    check("t2_hold_data", {13'd0, bus.wr_data}, 32'h20305);

    // Reset mid-load with two bytes buffered: nothing may be written afterwards.
    do_start(12'd5, 13'd1);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    rst = 1'b1;
    cycle();
    cycle();
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_ready", {31'd0, bus.in_ready}, 32'd0);
    check("t1_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("t1_wr_addr", {20'd0, bus.wr_addr}, 32'd0);
    check("t1_wr_data", {13'd0, bus.wr_data}, 32'd0);
    check("t1_done", {31'd0, done}, 32'd0);
    check("t1_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hCC;
    for (int i = 0; i < 6; i++) cycle();
    bus.in_valid = 1'b0;
    check("t1_state_idle", {30'd0, fsm_state}, 32'd0);

    // Zero-length load completes immediately.
    do_start(12'd9, 13'd0);
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    cycle();
    check("t3_done_pulse", {31'd0, done}, 32'd0);
    check("t3_busy2", {31'd0, busy}, 32'd0);

    // Address wrap from the top of memory.
    push_exp(12'd4095, 19'h33221);
    push_exp(12'd0, 19'h06655);
    do_start(12'd4095, 13'd2);
    send_word(8'h21, 8'h32, 8'h03, 0, 1'b0);
    send_word(8'h55, 8'h66, 8'h00, 0, 1'b0);
    cycle();
    check("t4_done", {31'd0, done}, 32'd1);
    cycle();

    // Upper bits in byte 2 flag err; word is written with them dropped.
    push_exp(12'd10, 19'h12211);
    do_start(12'd10, 13'd1);
    send_word(8'h11, 8'h22, 8'hF9, 0, 1'b0);
    check("t5_err_set", {31'd0, err}, 32'd1);
    check("t5_wr_hi", {29'd0, bus.wr_data[18:16]}, 32'd1);
    cycle();
    cycle();
    check("t5_err_sticky", {31'd0, err}, 32'd1);
    do_start(12'd0, 13'd0);
    check("t5_err_clear", {31'd0, err}, 32'd0);
    cycle();

    // Test 2 again with random valid gaps and start pulses while busy.
    push_exp(12'd2, 19'h18A2F);
    push_exp(12'd3, 19'h20305);
    do_start(12'd2, 13'd2);
    send_word(8'h2F, 8'h8A, 8'h01, 3, 1'b1);
    send_word(8'h05, 8'h03, 8'h02, 3, 1'b1);
    cycle();
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 4; i++) cycle();
    check("t6_idle", {30'd0, fsm_state}, 32'd0);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
